// File: rtl/jtsdram_check_pkg.sv
// Shared constants and helpers for the SDRAM read-back checker.
// Holds the fixed data width, the bank count and the expected-word bank mux.
// No state lives here; the checker FSM keeps its own encodings.
package jtsdram_check_pkg;

    localparam int DW    = 16;
    localparam int NBANK = 4;

    // Select the expected word for the bank being read.
    function automatic logic [DW-1:0] bank_word(
        input logic [1:0]    ba,
        input logic [DW-1:0] d0,
        input logic [DW-1:0] d1,
        input logic [DW-1:0] d2,
        input logic [DW-1:0] d3
    );
        logic [DW-1:0] w;
        case (ba)
            2'd0:    w = d0;
            2'd1:    w = d1;
            2'd2:    w = d2;
            default: w = d3;
        endcase
        return w;
    endfunction

endpackage

// File: rtl/jtsdram_check.sv
// SDRAM read-back verifier: sweeps all four banks word by word after a fill and
// compares each word read against the expected pattern from the generators.
// Ports: start/busy/done sweep control; ba0..3_data expected words at {rd_ba,rd_addr};
//        rd/rd_ack/rd_rdy/din controller read port; err/err_cnt sticky flag and
//        saturating count; err_addr/err_data/err_exp snapshot of the first mismatch.
module jtsdram_check
    import jtsdram_check_pkg::*;
#(
    parameter int AW          = 22,
    parameter int ERRW        = 16,
    parameter bit STOP_ON_ERR = 1'b0
) (
    input  logic            rst,
    input  logic            clk,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [DW-1:0]   ba0_data,
    input  logic [DW-1:0]   ba1_data,
    input  logic [DW-1:0]   ba2_data,
    input  logic [DW-1:0]   ba3_data,
    output logic [AW-1:0]   rd_addr,
    output logic [1:0]      rd_ba,
    output logic            rd,
    input  logic            rd_ack,
    input  logic            rd_rdy,
    input  logic [DW-1:0]   din,
    output logic            err,
    output logic [ERRW-1:0] err_cnt,
    output logic [AW+1:0]   err_addr,
    output logic [DW-1:0]   err_data,
    output logic [DW-1:0]   err_exp
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        WAIT = 3'd2,
        CMP  = 3'd3,
        FIN  = 3'd4
    } state_t;

    localparam logic [AW+1:0]   CNT_ONE = {{(AW+1){1'b0}}, 1'b1};
    localparam logic [ERRW-1:0] ERR_ONE = {{(ERRW-1){1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [AW+1:0]   cnt, cnt_nxt;
    logic [DW-1:0]   exp_q, exp_nxt;
    logic [DW-1:0]   cap_q, cap_nxt;
    logic            rd_nxt;
    logic            err_nxt;
    logic [ERRW-1:0] err_cnt_nxt;
    logic [AW+1:0]   err_addr_nxt;
    logic [DW-1:0]   err_data_nxt;
    logic [DW-1:0]   err_exp_nxt;
    logic            mismatch;

    // Bank is the slow field, word address the fast one.
    assign {rd_ba, rd_addr} = cnt;
    assign busy     = (state == REQ) || (state == WAIT) || (state == CMP);
    assign done     = (state == FIN);
    assign mismatch = (cap_q != exp_q);

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        exp_nxt      = exp_q;
        cap_nxt      = cap_q;
        rd_nxt       = 1'b0;
        err_nxt      = err;
        err_cnt_nxt  = err_cnt;
        err_addr_nxt = err_addr;
        err_data_nxt = err_data;
        err_exp_nxt  = err_exp;

        case (state)
            IDLE: ;
            REQ: begin
                // rd is registered, so rd=0 marks the first REQ cycle: the expected
                // word is latched there and the request goes out on the next cycle.
                // Acks and data are only honoured while our own request is up, which
                // also discards late data from a read abandoned by a restart.
                if (!rd) begin
                    exp_nxt = bank_word(rd_ba, ba0_data, ba1_data, ba2_data, ba3_data);
                    rd_nxt  = 1'b1;
                end else if (rd_ack) begin
                    if (rd_rdy) begin
                        cap_nxt   = din;
                        state_nxt = CMP;
                    end else begin
                        state_nxt = WAIT;
                    end
                end else begin
                    rd_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (rd_rdy) begin
                    cap_nxt   = din;
                    state_nxt = CMP;
                end
            end
            CMP: begin
                if (mismatch) begin
                    err_nxt = 1'b1;
                    if (!(&err_cnt)) begin
                        err_cnt_nxt = err_cnt + ERR_ONE;
                    end
                    if (!err) begin
                        err_addr_nxt = cnt;
                        err_data_nxt = cap_q;
                        err_exp_nxt  = exp_q;
                    end
                end
                // Stopping leaves cnt on the failing word so rd_ba/rd_addr show it.
                if ((&cnt) || (mismatch && STOP_ON_ERR)) begin
                    state_nxt = FIN;
                end else begin
                    cnt_nxt   = cnt + CNT_ONE;
                    state_nxt = REQ;
                end
            end
            FIN: ;
            default: state_nxt = IDLE;
        endcase

        // A start overrides whatever the current state wanted, acks and data included.
        if (start) begin
            state_nxt    = REQ;
            cnt_nxt      = '0;
            rd_nxt       = 1'b0;
            err_nxt      = 1'b0;
            err_cnt_nxt  = '0;
            err_addr_nxt = '0;
            err_data_nxt = '0;
            err_exp_nxt  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            exp_q    <= '0;
            cap_q    <= '0;
            rd       <= 1'b0;
            err      <= 1'b0;
            err_cnt  <= '0;
            err_addr <= '0;
            err_data <= '0;
            err_exp  <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            exp_q    <= exp_nxt;
            cap_q    <= cap_nxt;
            rd       <= rd_nxt;
            err      <= err_nxt;
            err_cnt  <= err_cnt_nxt;
            err_addr <= err_addr_nxt;
            err_data <= err_data_nxt;
            err_exp  <= err_exp_nxt;
        end
    end

endmodule

// File: tb/tb_jtsdram_check.sv
// Bench for jtsdram_check with three instances (AW=3): a free-running one, one that
// stops on the first error and one with a 2-bit error counter. A per-instance SDRAM
// controller model answers reads with configurable ack/data delays.
module tb_jtsdram_check;

    localparam int AW = 3;
    localparam int NW = 32;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [2:0]  start, busy, done, rd, rd_ack, rd_rdy, err;
    logic [15:0] din      [3];
    logic [2:0]  rd_addr  [3];
    logic [1:0]  rd_ba    [3];
    logic [4:0]  err_addr [3];
    logic [15:0] err_data [3];
    logic [15:0] err_exp  [3];
    logic [15:0] err_cnt0, err_cnt1;
    logic [1:0]  err_cnt2;
    logic [15:0] bd [3][4];

    function automatic logic [15:0] pat(input logic [4:0] a);
        return 16'h3C96 ^ {a, 6'b0, a};
    endfunction

    always_comb begin
        for (int k = 0; k < 3; k++)
            for (int b = 0; b < 4; b++)
                bd[k][b] = pat({2'(b), rd_addr[k]});
    end

    jtsdram_check #(.AW(AW), .ERRW(16), .STOP_ON_ERR(1'b0)) u_dut0 (
        .rst(rst), .clk(clk), .start(start[0]), .busy(busy[0]), .done(done[0]),
        .ba0_data(bd[0][0]), .ba1_data(bd[0][1]), .ba2_data(bd[0][2]), .ba3_data(bd[0][3]),
        .rd_addr(rd_addr[0]), .rd_ba(rd_ba[0]), .rd(rd[0]), .rd_ack(rd_ack[0]),
        .rd_rdy(rd_rdy[0]), .din(din[0]), .err(err[0]), .err_cnt(err_cnt0),
        .err_addr(err_addr[0]), .err_data(err_data[0]), .err_exp(err_exp[0]));

    jtsdram_check #(.AW(AW), .ERRW(16), .STOP_ON_ERR(1'b1)) u_dut1 (
        .rst(rst), .clk(clk), .start(start[1]), .busy(busy[1]), .done(done[1]),
        .ba0_data(bd[1][0]), .ba1_data(bd[1][1]), .ba2_data(bd[1][2]), .ba3_data(bd[1][3]),
        .rd_addr(rd_addr[1]), .rd_ba(rd_ba[1]), .rd(rd[1]), .rd_ack(rd_ack[1]),
        .rd_rdy(rd_rdy[1]), .din(din[1]), .err(err[1]), .err_cnt(err_cnt1),
        .err_addr(err_addr[1]), .err_data(err_data[1]), .err_exp(err_exp[1]));

    jtsdram_check #(.AW(AW), .ERRW(2), .STOP_ON_ERR(1'b0)) u_dut2 (
        .rst(rst), .clk(clk), .start(start[2]), .busy(busy[2]), .done(done[2]),
        .ba0_data(bd[2][0]), .ba1_data(bd[2][1]), .ba2_data(bd[2][2]), .ba3_data(bd[2][3]),
        .rd_addr(rd_addr[2]), .rd_ba(rd_ba[2]), .rd(rd[2]), .rd_ack(rd_ack[2]),
        .rd_rdy(rd_rdy[2]), .din(din[2]), .err(err[2]), .err_cnt(err_cnt2),
        .err_addr(err_addr[2]), .err_data(err_data[2]), .err_exp(err_exp[2]));

    // ---------------- controller model ----------------
    logic [15:0] mem [3][NW];
    logic [4:0]  pend [3];
    int          wcnt [3], rtim [3], stray [3], seq [3], obad [3];
    bit          acked [3], req_start [3], arm [3];
    int          ack_d, rdy_d;

    initial begin
        start = '0; rd_ack = '0; rd_rdy = '0;
        for (int k = 0; k < 3; k++) begin
            din[k] = '0; pend[k] = '0; wcnt[k] = 0; rtim[k] = 0; stray[k] = 0;
            seq[k] = 0; obad[k] = 0; acked[k] = 0; req_start[k] = 0; arm[k] = 0;
        end
        forever begin
            @(negedge clk);
            for (int k = 0; k < 3; k++) begin
                rd_ack[k] = 1'b0;
                rd_rdy[k] = 1'b0;
                start[k]  = 1'b0;
                if (req_start[k]) begin
                    start[k] = 1'b1; req_start[k] = 0;
                    rtim[k] = 0; wcnt[k] = 0; acked[k] = 0; seq[k] = 0; obad[k] = 0;
                end
                if (rtim[k] > 0) begin
                    rtim[k]--;
                    if (rtim[k] == 0) begin rd_rdy[k] = 1'b1; din[k] = mem[k][pend[k]]; end
                end
                if (stray[k] > 0) begin
                    rd_rdy[k] = 1'b1; din[k] = 16'hDEAD; stray[k]--;
                end
                if (rd[k] && !acked[k] && !start[k]) begin
                    if (wcnt[k] >= ack_d) begin
                        rd_ack[k] = 1'b1; acked[k] = 1; wcnt[k] = 0;
                        pend[k] = {rd_ba[k], rd_addr[k]};
                        if (pend[k] != 5'(seq[k])) obad[k]++;
                        seq[k]++;
                        if (rdy_d == 0) begin rd_rdy[k] = 1'b1; din[k] = mem[k][pend[k]]; end
                        else rtim[k] = rdy_d;
                        if (arm[k] && pend[k] == 5'd10) begin
                            arm[k] = 0; req_start[k] = 1; stray[k] = 2;
                            for (int a = 0; a < NW; a++) mem[k][a] = pat(5'(a));
                        end
                    end else begin
                        wcnt[k]++;
                    end
                end
                if (!rd[k]) acked[k] = 0;
            end
        end
    end

    // ---------------- checking ----------------
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h want=%0h", name, act, exp);
        end
    endtask

    task automatic fill(input int k, input logic [31:0] mask);
        for (int a = 0; a < NW; a++)
            mem[k][a] = pat(5'(a)) ^ (mask[a] ? 16'h0100 : 16'h0000);
    endtask

    // Starts a sweep on instance k and returns cycles until done (-1 on timeout).
    task automatic run(input int k, output int cyc);
        int t;
        req_start[k] = 1;
        t = 0;
        while (!start[k] && t < 10) begin @(negedge clk); #1; t++; end
        cyc = 0;
        while (cyc < 5000) begin
            @(posedge clk); #1;
            if (done[k]) break;
            cyc++;
        end
        if (cyc >= 5000) begin
            cyc = -1;
            chk("sweep_timeout", 32'd1, 32'd0);
        end
    endtask

    typedef struct {
        string       name;
        int          ack_d, rdy_d;
        logic [31:0] mask;
        logic        e_err;
        int          e_cnt;
        logic [4:0]  e_addr;
        int          e_cyc;
    } vec_t;

    vec_t tbl [5];
    int   cyc, t, n;

    initial begin
        tbl[0] = '{"clean",     2, 3, 32'h0000_0000, 1'b0, 0, 5'h00, 256};
        tbl[1] = '{"one_bad",   2, 3, 32'h0020_0000, 1'b1, 1, 5'h15, 256};
        tbl[2] = '{"three_bad", 2, 3, 32'h4020_0010, 1'b1, 3, 5'h04, 256};
        tbl[3] = '{"zero_lat",  0, 0, 32'h0000_0000, 1'b0, 0, 5'h00, 96};
        tbl[4] = '{"ends_bad",  0, 0, 32'h8000_0001, 1'b1, 2, 5'h00, 96};
        ack_d = 2; rdy_d = 3;
        for (int k = 0; k < 3; k++) fill(k, 32'h0);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_ctrl", {29'd0, busy[0], done[0], rd[0]}, 32'd0);
        chk("reset_err", {11'd0, err[0], err_cnt0, err_addr[0]}, 32'd0);
        chk("reset_snap", {err_data[0], err_exp[0]}, 32'd0);
        chk("reset_addr", {27'd0, rd_ba[0], rd_addr[0]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_after_reset", {30'd0, busy[0], done[0]}, 32'd0);

        for (int i = 0; i < 5; i++) begin
            ack_d = tbl[i].ack_d; rdy_d = tbl[i].rdy_d;
            fill(0, tbl[i].mask);
            run(0, cyc);
            chk({tbl[i].name, "_done"}, {31'd0, done[0]}, 32'd1);
            chk({tbl[i].name, "_err"}, {31'd0, err[0]}, {31'd0, tbl[i].e_err});
            chk({tbl[i].name, "_cnt"}, {16'd0, err_cnt0}, tbl[i].e_cnt);
            chk({tbl[i].name, "_addr"}, {27'd0, err_addr[0]}, {27'd0, tbl[i].e_addr});
            chk({tbl[i].name, "_cyc_ok"},
                {31'd0, (cyc >= tbl[i].e_cyc - 2) && (cyc <= tbl[i].e_cyc + 2)}, 32'd1);
            chk({tbl[i].name, "_reads"}, seq[0], NW);
            chk({tbl[i].name, "_order"}, obad[0], 0);
            if (tbl[i].e_err) begin
                chk({tbl[i].name, "_exp"}, {16'd0, err_exp[0]}, {16'd0, pat(tbl[i].e_addr)});
                chk({tbl[i].name, "_xor"}, {16'd0, err_data[0] ^ err_exp[0]}, 32'h0100);
            end
        end

        // done holds while idle in FIN
        repeat (5) @(posedge clk);
        #1;
        chk("done_held", {30'd0, done[0], busy[0]}, 32'd2);

        // Restart at word 10 while waiting for data, with stray rdy on the start
        // cycle and the next one; a prior error at word 3 must be wiped.
        ack_d = 2; rdy_d = 3;
        fill(0, 32'h0000_0008);
        arm[0] = 1;
        req_start[0] = 1;
        n = 0; t = 0;
        while (n < 2 && t < 2000) begin
            @(negedge clk); #1; t++;
            if (start[0]) n++;
        end
        chk("restart_seen", n, 2);
        chk("restart_err_before", {31'd0, err[0]}, 32'd1);
        chk("restart_busy_before", {31'd0, busy[0]}, 32'd1);
        @(posedge clk); #1;
        chk("restart_clr_err", {11'd0, err[0], err_cnt0, err_addr[0]}, 32'd0);
        chk("restart_clr_snap", {err_data[0], err_exp[0]}, 32'd0);
        chk("restart_ctrl", {29'd0, busy[0], done[0], rd[0]}, 32'd4);
        chk("restart_addr", {27'd0, rd_ba[0], rd_addr[0]}, 32'd0);
        t = 0;
        while (!done[0] && t < 5000) begin @(posedge clk); #1; t++; end
        chk("restart_done", {31'd0, done[0]}, 32'd1);
        chk("restart_clean", {15'd0, err[0], err_cnt0}, 32'd0);
        chk("restart_reads", seq[0], NW);
        chk("restart_order", obad[0], 0);

        // STOP_ON_ERR=1: finish at the first bad word and keep pointing at it
        fill(1, 32'h0020_0010);
        run(1, cyc);
        chk("stop_done", {30'd0, done[1], busy[1]}, 32'd2);
        chk("stop_cnt", {16'd0, err_cnt1}, 32'd1);
        chk("stop_addr", {27'd0, err_addr[1]}, 32'h04);
        chk("stop_ptr", {27'd0, rd_ba[1], rd_addr[1]}, 32'h04);
        chk("stop_reads", seq[1], 5);
        chk("stop_xor", {16'd0, err_data[1] ^ err_exp[1]}, 32'h0100);

        // ERRW=2: counter saturates with every word bad
        ack_d = 0; rdy_d = 0;
        fill(2, 32'hFFFF_FFFF);
        run(2, cyc);
        chk("sat_done", {31'd0, done[2]}, 32'd1);
        chk("sat_cnt", {30'd0, err_cnt2}, 32'd3);
        chk("sat_err", {27'd0, err[2], err_addr[2][3:0]}, 32'h10);
        chk("sat_reads", seq[2], NW);

        // asynchronous reset in the middle of a sweep
        req_start[2] = 1;
        repeat (20) @(posedge clk);
        #1;
        chk("mid_busy", {31'd0, busy[2]}, 32'd1);
        chk("mid_err", {31'd0, err[2]}, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_ctrl", {20'd0, busy[2], done[2], rd[2], err[2], err_cnt2, rd_ba[2], rd_addr[2]}, 32'd0);
        chk("arst_snap", {err_addr[2], err_data[2][10:0], err_exp[2]}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk); #1;
        chk("arst_idle", {29'd0, busy[2], done[2], rd[2]}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
